// File: rtl/mc_control_if.sv
// ============================================================================
// Module      : mc_control_if
// Description : Multicycle datapath control bundle between mc_control and the datapath.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mc_control_if;
    logic       mem_ready;
    logic [5:0] opcode;
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_write;
    logic       reg_dst;
    logic       alu_src_a;
    logic [1:0] alu_op;
    logic [1:0] alu_src_b;
    logic [1:0] pc_source;

    modport master (
        input  mem_ready, opcode,
        output pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_write, reg_dst, alu_src_a, alu_op, alu_src_b,
               pc_source
    );

    modport slave (
        output mem_ready, opcode,
        input  pc_write, pc_write_cond, iord, mem_read, mem_write, ir_write,
               mem_to_reg, reg_write, reg_dst, alu_src_a, alu_op, alu_src_b,
               pc_source
    );
endinterface

`default_nettype wire

// File: rtl/mc_control.sv
// ============================================================================
// Module      : mc_control
// Description : Multicycle MIPS-style control FSM with retired-instruction
//               counter and sticky illegal-opcode flag. Define
//               MC_CONTROL_STEP_EN to advance one state per step pulse.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mc_control #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             step,
    mc_control_if.master          bus,
    output logic [3:0]            state,
    output logic [CNT_W-1:0]      inst_cnt,
    output logic                  illegal
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_RWB   = 4'd7,
        S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_IEXEC  = 4'd10, S_IWB   = 4'd11
    } state_t;

    localparam logic [5:0] c_OP_RTYPE = 6'b000000;
    localparam logic [5:0] c_OP_LW    = 6'b100011;
    localparam logic [5:0] c_OP_SW    = 6'b101011;
    localparam logic [5:0] c_OP_BEQ   = 6'b000100;
    localparam logic [5:0] c_OP_J     = 6'b000010;
    localparam logic [5:0] c_OP_ADDI  = 6'b001000;

    state_t           r_state;
    state_t           w_next;
    logic             w_go;
    logic             w_adv;
    logic             w_stb;
    logic             w_op_ok;
    logic [CNT_W-1:0] r_inst_cnt;
    logic             r_illegal;

`ifdef MC_CONTROL_STEP_EN
    assign w_go = step;
`else
    // step participates only so the port stays referenced; go is constant 1
    assign w_go = step | 1'b1;
`endif

    assign w_adv = w_go && (bus.mem_ready ||
                   !(r_state inside {S_FETCH, S_MEMRD, S_MEMWR}));
    // Strobes are held off while reset is asserted, even though adv may be high
    assign w_stb = w_adv && rst;

    assign w_op_ok = bus.opcode inside {c_OP_RTYPE, c_OP_LW, c_OP_SW,
                                        c_OP_BEQ, c_OP_J, c_OP_ADDI};

    always_comb begin
        w_next = S_FETCH;
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    c_OP_RTYPE:       w_next = S_EXEC;
                    c_OP_LW, c_OP_SW: w_next = S_MEMADR;
                    c_OP_BEQ:         w_next = S_BRANCH;
                    c_OP_J:           w_next = S_JUMP;
                    c_OP_ADDI:        w_next = S_IEXEC;
                    default:          w_next = S_FETCH;
                endcase
            end
            S_MEMADR: w_next = (bus.opcode == c_OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:  w_next = S_MEMWB;
            S_EXEC:   w_next = S_RWB;
            S_IEXEC:  w_next = S_IWB;
            default:  w_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_FETCH;
            r_inst_cnt <= '0;
            r_illegal  <= 1'b0;
        end else if (w_adv) begin
            r_state <= w_next;
            if (w_next == S_FETCH)
                r_inst_cnt <= r_inst_cnt + CNT_W'(1);
            if (r_state == S_DECODE && !w_op_ok)
                r_illegal <= 1'b1;
        end
    end

    always_comb begin
        bus.pc_write      = 1'b0;
        bus.pc_write_cond = 1'b0;
        bus.iord          = 1'b0;
        bus.mem_read      = 1'b0;
        bus.mem_write     = 1'b0;
        bus.ir_write      = 1'b0;
        bus.mem_to_reg    = 1'b0;
        bus.reg_write     = 1'b0;
        bus.reg_dst       = 1'b0;
        bus.alu_src_a     = 1'b0;
        bus.alu_op        = 2'b00;
        bus.alu_src_b     = 2'b00;
        bus.pc_source     = 2'b00;
        case (r_state)
            S_FETCH: begin
                bus.mem_read  = 1'b1;
                bus.alu_src_b = 2'b01;
                bus.pc_write  = w_stb;
                bus.ir_write  = w_stb;
            end
            S_DECODE: bus.alu_src_b = 2'b11;
            S_MEMADR, S_IEXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                bus.iord     = 1'b1;
                bus.mem_read = 1'b1;
            end
            S_MEMWR: begin
                bus.iord      = 1'b1;
                bus.mem_write = w_stb;
            end
            S_MEMWB: begin
                bus.mem_to_reg = 1'b1;
                bus.reg_write  = w_stb;
            end
            S_EXEC: begin
                bus.alu_src_a = 1'b1;
                bus.alu_op    = 2'b10;
            end
            S_RWB: begin
                bus.reg_dst   = 1'b1;
                bus.reg_write = w_stb;
            end
            S_IWB: bus.reg_write = w_stb;
            S_BRANCH: begin
                bus.alu_src_a     = 1'b1;
                bus.alu_op        = 2'b01;
                bus.pc_source     = 2'b01;
                bus.pc_write_cond = w_stb;
            end
            S_JUMP: begin
                bus.pc_source = 2'b10;
                bus.pc_write  = w_stb;
            end
            default: ;
        endcase
    end

    assign state    = r_state;
    assign inst_cnt = r_inst_cnt;
    assign illegal  = r_illegal;

endmodule

`default_nettype wire

// File: tb/tb_mc_control.sv
// ============================================================================
// Module      : tb_mc_control
// Description : Directed scoreboard bench for mc_control (CNT_W=4).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mc_control;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             step = 1'b0;
    logic [3:0]       state;
    logic [CNT_W-1:0] inst_cnt;
    logic             illegal;

    mc_control_if bus ();

    mc_control #(.CNT_W(CNT_W)) dut (
        .clk      (clk),
        .rst      (rst),
        .step     (step),
        .bus      (bus.master),
        .state    (state),
        .inst_cnt (inst_cnt),
        .illegal  (illegal)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] st;
        logic       rdy;
    } item_t;

    item_t q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int pcw, irw, mw, rw, pwc, rd_ok, mtr_ok, wait_lvl;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [3:0] st, input logic rdy);
        item_t it;
        it.st  = st;
        it.rdy = rdy;
        q.push_back(it);
    endtask

    // Pops one expected state per clock, drives that cycle's mem_ready,
    // and tallies strobes seen mid-cycle.
    task automatic run_seq(input string tag);
        item_t it;
        pcw = 0; irw = 0; mw = 0; rw = 0; pwc = 0;
        rd_ok = 0; mtr_ok = 0; wait_lvl = 0;
        while (q.size() > 0) begin
            it = q.pop_front();
            bus.mem_ready = it.rdy;
            @(negedge clk);
            chk(tag, 32'(state), 32'(it.st));
            pcw += int'(bus.pc_write);
            irw += int'(bus.ir_write);
            mw  += int'(bus.mem_write);
            rw  += int'(bus.reg_write);
            pwc += int'(bus.pc_write_cond);
            if (state == 4'd7 && bus.reg_write && bus.reg_dst) rd_ok++;
            if (state == 4'd4 && bus.reg_write && bus.mem_to_reg) mtr_ok++;
            if (state == 4'd3 && !it.rdy && bus.mem_read && bus.iord) wait_lvl++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        bus.mem_ready = 1'b1;
        bus.opcode    = 6'b000000;
`ifdef MC_CONTROL_STEP_EN
        step = 1'b1;
`endif
        #1 rst = 1'b0;
        #1;
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_cnt", 32'(inst_cnt), 32'd0);
        chk("rst_illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        chk("rst_pc_write", 32'(bus.pc_write), 32'd0);
        chk("rst_ir_write", 32'(bus.ir_write), 32'd0);
        chk("rst_hold", 32'(state), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // R-type
        bus.opcode = 6'b000000;
        push(0, 1); push(1, 1); push(6, 1); push(7, 1);
        run_seq("rtype_state");
        chk("rtype_cnt", 32'(inst_cnt), 32'd1);
        chk("rtype_rw", rw, 1);
        chk("rtype_regdst", rd_ok, 1);
        chk("rtype_pcw", pcw, 1);
        chk("rtype_irw", irw, 1);

        // lw with three wait cycles in MEMRD
        bus.opcode = 6'b100011;
        push(0, 1); push(1, 1); push(2, 1);
        push(3, 0); push(3, 0); push(3, 0); push(3, 1); push(4, 1);
        run_seq("lw_state");
        chk("lw_state_end", 32'(state), 32'd0);
        chk("lw_rw", rw, 1);
        chk("lw_memtoreg", mtr_ok, 1);
        chk("lw_wait_levels", wait_lvl, 3);
        chk("lw_cnt", 32'(inst_cnt), 32'd2);

        // illegal opcode
        bus.opcode = 6'b111111;
        push(0, 1); push(1, 1);
        run_seq("ill_state");
        chk("ill_state_end", 32'(state), 32'd0);
        chk("ill_flag", 32'(illegal), 32'd1);
        chk("ill_cnt", 32'(inst_cnt), 32'd3);
        chk("ill_rw", rw, 0);
        chk("ill_mw", mw, 0);

        // sw with wait cycles in FETCH and MEMWR
        bus.opcode = 6'b101011;
        push(0, 0); push(0, 1); push(1, 1); push(2, 1); push(5, 0); push(5, 1);
        run_seq("sw_state");
        chk("sw_mw", mw, 1);
        chk("sw_pcw", pcw, 1);
        chk("sw_irw", irw, 1);
        chk("sw_cnt", 32'(inst_cnt), 32'd4);
        chk("sw_illegal_sticky", 32'(illegal), 32'd1);

        // beq
        bus.opcode = 6'b000100;
        push(0, 1); push(1, 1); push(8, 1);
        run_seq("beq_state");
        chk("beq_pwc", pwc, 1);
        chk("beq_pcw", pcw, 1);

        // addi
        bus.opcode = 6'b001000;
        push(0, 1); push(1, 1); push(10, 1); push(11, 1);
        run_seq("addi_state");
        chk("addi_rw", rw, 1);
        chk("addi_cnt", 32'(inst_cnt), 32'd6);

        // asynchronous reset while parked in MEMWR
        bus.opcode = 6'b101011;
        push(0, 1); push(1, 1); push(2, 1);
        run_seq("rstmw_state");
        bus.mem_ready = 1'b0;
        chk("rstmw_in_memwr", 32'(state), 32'd5);
        #2 rst = 1'b0;
        #1;
        chk("rstmw_state0", 32'(state), 32'd0);
        chk("rstmw_cnt0", 32'(inst_cnt), 32'd0);
        chk("rstmw_illegal0", 32'(illegal), 32'd0);
        chk("rstmw_no_mw", 32'(bus.mem_write), 32'd0);
        bus.mem_ready = 1'b1;
        @(negedge clk);
        chk("rstmw_no_pcw", 32'(bus.pc_write), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;

        // counter wrap with jumps
        bus.opcode = 6'b000010;
        for (int i = 0; i < 15; i++) begin
            push(0, 1); push(1, 1); push(9, 1);
        end
        run_seq("jmp_state");
        chk("jmp_cnt_max", 32'(inst_cnt), 32'd15);
        push(0, 1); push(1, 1); push(9, 1);
        run_seq("jmp_last_state");
        chk("jmp_cnt_wrap", 32'(inst_cnt), 32'd0);
        chk("jmp_pcw", pcw, 2);

`ifdef MC_CONTROL_STEP_EN
        begin
            logic [3:0] exp_st [4];
            logic [3:0] prev;
            exp_st = '{4'd1, 4'd2, 4'd5, 4'd0};
            step = 1'b0;
            bus.opcode = 6'b101011;
            bus.mem_ready = 1'b1;
            prev = 4'd0;
            mw = 0;
            for (int k = 0; k < 4; k++) begin
                repeat (10) begin
                    @(negedge clk);
                    mw += int'(bus.mem_write);
                end
                chk("step_hold", 32'(state), 32'(prev));
                step = 1'b1;
                @(negedge clk);
                mw += int'(bus.mem_write);
                @(posedge clk);
                #1 step = 1'b0;
                chk("step_adv", 32'(state), 32'(exp_st[k]));
                prev = exp_st[k];
            end
            chk("step_mw", mw, 1);
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
